mem_cache_controller: RTL and testbench

- Direct-mapped, write-through, no-write-allocate data cache controller placed between the MEM stage request signals and the SRAM controller handshake.
- Serves read hits in zero added cycles and forwards read misses and all writes to the SRAM controller.
- Drives ready, which the pipeline uses as its freeze/stall condition (freeze = ~ready).
- Keeps saturating hit and miss counters for performance measurement.

---
 rtl/mem_cache_controller.sv | 143 ++++++++++++++
 tb/tb_mem_cache_controller.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mem_cache_controller.sv
// Direct-mapped, write-through, no-write-allocate data cache between the MEM stage
// and the SRAM controller. Read hits complete with no added cycles. Read misses and
// all writes go to SRAM. Saturating hit and miss counters are kept for profiling.
module mem_cache_controller #(
    parameter logic [31:0] BASE_ADDR = 32'd1024,
    parameter int unsigned INDEX_W   = 6,
    parameter int unsigned OFF_W     = 19,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_r_en,
    input  logic             mem_w_en,
    input  logic [31:0]      address,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic             ready,
    output logic             sram_r_en,
    output logic             sram_w_en,
    output logic [31:0]      sram_addr,
    output logic [31:0]      sram_wdata,
    input  logic [31:0]      sram_rdata,
    input  logic             sram_ready,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);

    localparam int unsigned LINES = 2 ** INDEX_W;
    localparam int unsigned TAG_W = OFF_W - INDEX_W - 2;

    typedef enum logic [1:0] {StIdle, StRdMiss, StWr} state_e;

    state_e             r_state;
    state_e             w_state_next;

    logic [LINES-1:0]   r_valid;
    logic [TAG_W-1:0]   r_tag_mem  [LINES];
    logic [31:0]        r_data_mem [LINES];
    logic [CNT_W-1:0]   r_hit_cnt;
    logic [CNT_W-1:0]   r_miss_cnt;

    logic [31:0]        w_off;
    logic [INDEX_W-1:0] w_idx;
    logic [TAG_W-1:0]   w_tag;
    logic               w_hit;
    logic               w_hit_inc;
    logic               w_miss_inc;
    logic               w_fill;
    logic               w_wr_update;

    // Offset is relative to the start of data memory; the byte bits are ignored.
    assign w_off = address - BASE_ADDR;
    assign w_idx = w_off[INDEX_W+1:2];
    assign w_tag = w_off[OFF_W-1:INDEX_W+2];
    assign w_hit = r_valid[w_idx] && (r_tag_mem[w_idx] == w_tag);

    // SRAM enables come straight from the state register, so they are glitch-free
    // and mutually exclusive.
    assign sram_r_en  = (r_state == StRdMiss);
    assign sram_w_en  = (r_state == StWr);
    assign sram_addr  = address;
    assign sram_wdata = wdata;
    assign hit_count  = r_hit_cnt;
    assign miss_count = r_miss_cnt;

    // Next-state, ready/rdata and update strobes.
    always_comb begin
        w_state_next = r_state;
        ready        = 1'b1;
        rdata        = 32'h0;
        w_hit_inc    = 1'b0;
        w_miss_inc   = 1'b0;
        w_fill       = 1'b0;
        w_wr_update  = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (mem_w_en) begin
                    ready        = 1'b0;
                    w_state_next = StWr;
                end else if (mem_r_en) begin
                    if (w_hit) begin
                        rdata     = r_data_mem[w_idx];
                        w_hit_inc = 1'b1;
                    end else begin
                        ready        = 1'b0;
                        w_state_next = StRdMiss;
                    end
                end
            end
            StRdMiss: begin
                ready = sram_ready;
                if (sram_ready) begin
                    rdata        = sram_rdata;
                    w_fill       = 1'b1;
                    w_miss_inc   = 1'b1;
                    w_state_next = StIdle;
                end
            end
            StWr: begin
                ready = sram_ready;
                if (sram_ready) begin
                    w_wr_update  = w_hit;
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // State, valid bits and saturating counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StIdle;
            r_valid    <= '0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_fill) begin
                r_valid[w_idx] <= 1'b1;
            end
            if (w_hit_inc && (r_hit_cnt != {CNT_W{1'b1}})) begin
                r_hit_cnt <= r_hit_cnt + 1'b1;
            end
            if (w_miss_inc && (r_miss_cnt != {CNT_W{1'b1}})) begin
                r_miss_cnt <= r_miss_cnt + 1'b1;
            end
        end
    end

    // Tag and data arrays; contents are don't-care until the valid bit is set.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_fill) begin
                r_tag_mem[w_idx]  <= w_tag;
                r_data_mem[w_idx] <= sram_rdata;
            end else if (w_wr_update) begin
                r_data_mem[w_idx] <= wdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_cache_controller.sv
// Self-checking bench for mem_cache_controller: a behavioural cache/SRAM model
// predicts rdata, stall length and counters; expected rdata goes through a queue.
module tb_mem_cache_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_r_en, mem_w_en;
    logic [31:0] address, wdata;
    logic [31:0] rdata, sram_addr, sram_wdata, sram_rdata;
    logic        ready, sram_r_en, sram_w_en, sram_ready;
    logic [15:0] hit_count, miss_count;

    // Narrow-counter copy sharing the same stimulus, for saturation checks.
    logic [31:0] s_rdata, s_sram_addr, s_sram_wdata;
    logic        s_ready, s_sram_r_en, s_sram_w_en;
    logic [1:0]  s_hit_count, s_miss_count;

    always #5 clk = ~clk;

    mem_cache_controller dut (
        .clk(clk), .rst(rst), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .address(address), .wdata(wdata), .rdata(rdata), .ready(ready),
        .sram_r_en(sram_r_en), .sram_w_en(sram_w_en), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_ready(sram_ready),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    mem_cache_controller #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .address(address), .wdata(wdata), .rdata(s_rdata), .ready(s_ready),
        .sram_r_en(s_sram_r_en), .sram_w_en(s_sram_w_en), .sram_addr(s_sram_addr),
        .sram_wdata(s_sram_wdata), .sram_rdata(sram_rdata), .sram_ready(sram_ready),
        .hit_count(s_hit_count), .miss_count(s_miss_count)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_q[$];

    bit          m_valid [64];
    logic [10:0] m_tag   [64];
    logic [31:0] m_data  [64];
    int unsigned m_hits, m_misses;
    logic [31:0] sram_mem [logic [31:0]];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic [31:0] sram_read(input logic [31:0] a);
        if (sram_mem.exists(a)) return sram_mem[a];
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] sat(input int unsigned v, input int unsigned max);
        return (v > max) ? max : v;
    endfunction

    task automatic check_counters(input string tag);
        check_val({tag, "_hits"},     {16'h0, hit_count},    sat(m_hits, 65535));
        check_val({tag, "_misses"},   {16'h0, miss_count},   sat(m_misses, 65535));
        check_val({tag, "_hits_s"},   {30'h0, s_hit_count},  sat(m_hits, 3));
        check_val({tag, "_misses_s"}, {30'h0, s_miss_count}, sat(m_misses, 3));
    endtask

    // One request held until ready; SRAM answers on the lat-th cycle of its enable.
    task automatic xact(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input int lat);
        logic [31:0] off, exp;
        logic [10:0] tg;
        int          idx, en_cnt, low_cnt, cyc, exp_stall;
        bit          hit, done, saw_r, saw_w, both;
        off  = a - 32'd1024;
        idx  = int'(off[7:2]);
        tg   = off[18:8];
        hit  = m_valid[idx] && (m_tag[idx] == tg);
        if (wr) exp = 32'h0;
        else if (hit) exp = m_data[idx];
        else exp = sram_read(a);
        exp_q.push_back(exp);
        mem_r_en = rd; mem_w_en = wr; address = a; wdata = d;
        en_cnt = 0; low_cnt = 0; cyc = 0; done = 0; saw_r = 0; saw_w = 0; both = 0;
        while (!done && cyc < 40) begin
            sram_ready = (sram_r_en || sram_w_en) && (en_cnt == lat - 1);
            sram_rdata = (sram_ready && sram_r_en) ? sram_read(a) : 32'h0;
            #1;
            if (sram_r_en) saw_r = 1;
            if (sram_w_en) saw_w = 1;
            if (sram_r_en && sram_w_en) both = 1;
            if (sram_r_en || sram_w_en) en_cnt++;
            if (ready) begin
                done = 1;
                check_val("rdata", rdata, exp_q.pop_front());
            end else begin
                low_cnt++;
            end
            @(negedge clk);
            cyc++;
        end
        mem_r_en = 0; mem_w_en = 0; sram_ready = 0; sram_rdata = 32'h0;
        if (!done) begin
            check_val("timeout", 32'd0, 32'd1);
            void'(exp_q.pop_front());
        end
        exp_stall = (wr || !hit) ? lat : 0;
        check_val("stall_cycles", low_cnt, exp_stall);
        check_val("sram_en_cycles", en_cnt, exp_stall);
        check_val("saw_sram_r", saw_r, !wr && !hit);
        check_val("saw_sram_w", saw_w, wr);
        check_val("both_en", both, 1'b0);
        if (wr) begin
            if (hit) m_data[idx] = d;
            sram_mem[a] = d;
        end else if (hit) begin
            m_hits++;
        end else begin
            m_valid[idx] = 1; m_tag[idx] = tg; m_data[idx] = exp;
            m_misses++;
        end
        #1;
        check_counters("cnt");
        check_val("idle_ready", ready, 1'b1);
        check_val("idle_rdata", rdata, 32'h0);
        @(negedge clk);
    endtask

    // Reset asserted while a read miss is waiting on SRAM.
    task automatic reset_mid_miss(input logic [31:0] a);
        mem_r_en = 1; address = a; sram_ready = 0;
        repeat (3) @(negedge clk);
        check_val("rd_miss_pending", sram_r_en, 1'b1);
        rst = 1;
        @(negedge clk);
        rst = 0; mem_r_en = 0;
        #1;
        check_val("rst_sram_r_en", sram_r_en, 1'b0);
        check_val("rst_ready", ready, 1'b1);
        check_val("rst_rdata", rdata, 32'h0);
        for (int i = 0; i < 64; i++) m_valid[i] = 0;
        m_hits = 0; m_misses = 0;
        check_counters("rst_cnt");
        @(negedge clk);
    endtask

    initial begin
        rst = 1; mem_r_en = 0; mem_w_en = 0; address = 0; wdata = 0;
        sram_ready = 0; sram_rdata = 0;
        m_hits = 0; m_misses = 0;
        for (int i = 0; i < 64; i++) m_valid[i] = 0;
        repeat (2) @(negedge clk);
        rst = 0;
        #1;
        check_val("reset_ready", ready, 1'b1);
        check_val("reset_rdata", rdata, 32'h0);
        check_val("reset_sram_r", sram_r_en, 1'b0);
        check_val("reset_sram_w", sram_w_en, 1'b0);
        check_counters("reset_cnt");
        @(negedge clk);

        sram_mem[32'd1024] = 32'hDEAD_BEEF;
        xact(1, 0, 32'd1024, 32'h0, 5);            // cold miss
        xact(1, 0, 32'd1024, 32'h0, 1);            // hit
        xact(0, 1, 32'd1024, 32'h1234_5678, 3);    // write hit
        xact(1, 0, 32'd1026, 32'h0, 1);            // hit, byte bits ignored
        xact(0, 1, 32'd2048, 32'hCAFE_F00D, 2);    // write miss, line 0 untouched
        xact(1, 0, 32'd1024, 32'h0, 1);
        xact(1, 0, 32'd2048, 32'h0, 2);            // miss, refills line 0
        xact(1, 0, 32'd1024, 32'h0, 2);
        xact(1, 0, 32'd1280, 32'h0, 3);            // conflict on line 0
        xact(1, 0, 32'd1024, 32'h0, 1);
        for (int i = 1; i < 6; i++) begin
            xact(1, 0, 32'd1024 + 32'(4 * i), 32'h0, 1 + (i % 3));
            xact(1, 0, 32'd1024 + 32'(4 * i), 32'h0, 1);
        end
        xact(1, 0, 32'd100, 32'h0, 2);             // below base, offset wraps
        xact(1, 0, 32'd100, 32'h0, 1);

        reset_mid_miss(32'd1536);
        xact(1, 0, 32'd1024, 32'h0, 2);            // cache was invalidated
        xact(1, 1, 32'd1024, 32'hA5A5_5A5A, 2);    // both enables: a write
        for (int i = 0; i < 5; i++) xact(1, 0, 32'd1024, 32'h0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
